// File: rtl/counter_fw_pkg.sv
// Shared constants and enumerations for the counter firewall.
package counter_fw_pkg;

    localparam logic [2:0] CODE_NONE = 3'd0;
    localparam logic [2:0] CODE_OVF  = 3'd1;
    localparam logic [2:0] CODE_LOAD = 3'd2;
    localparam logic [2:0] CODE_INC  = 3'd3;
    localparam logic [2:0] CODE_HOLD = 3'd4;

    localparam int FLAG_OVF  = 0;
    localparam int FLAG_LOAD = 1;
    localparam int FLAG_INC  = 2;
    localparam int FLAG_HOLD = 3;

    typedef enum logic [1:0] {ST_UNSYNC, ST_TRACK, ST_HALTED} fw_state_e;
    typedef enum logic [1:0] {OP_LOAD, OP_INC, OP_HOLD} fw_op_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear and inc together yield 1.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= inc ? WIDTH'(1) : '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/counter_firewall.sv
// Shadows a monitored counter, flags overflow and load/inc/hold mismatches,
// and keeps sticky flags, a saturating error count and a first-error capture.
module counter_firewall
    import counter_fw_pkg::*;
#(
    parameter int WIDTH       = 3,
    parameter int CNT_W       = 8,
    parameter int WRAP_OK     = 0,
    parameter int STOP_ON_ERR = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             inc,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] data_out,
    input  logic             err_clr,
    output logic [3:0]       err_flags,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [2:0]       first_err_code,
    output logic [WIDTH-1:0] first_err_data
);

    fw_state_e        state;
    fw_op_e           op_q;
    fw_op_e           op_nxt;
    logic [WIDTH-1:0] exp_q;
    logic [WIDTH-1:0] exp_nxt;
    logic [WIDTH-1:0] base;
    logic             chk;
    logic             mism;
    logic             ovf;
    logic [3:0]       new_flags;
    logic [2:0]       new_code;
    logic             any_err;

    assign chk  = (state == ST_TRACK);
    assign mism = chk && (data_out != exp_q);
    assign ovf  = chk && (WRAP_OK == 0) && inc && !ld && (data_out == '1);

    // After a mismatch the prediction restarts from what the counter shows.
    assign base    = ((state == ST_UNSYNC) || mism) ? data_out : exp_q;
    assign exp_nxt = ld ? data_in : (inc ? base + WIDTH'(1) : base);
    assign op_nxt  = ld ? OP_LOAD : (inc ? OP_INC : OP_HOLD);

    always_comb begin
        new_flags           = '0;
        new_flags[FLAG_OVF] = ovf;
        if (mism) begin
            case (op_q)
                OP_LOAD: new_flags[FLAG_LOAD] = 1'b1;
                OP_INC:  new_flags[FLAG_INC]  = 1'b1;
                default: new_flags[FLAG_HOLD] = 1'b1;
            endcase
        end
    end

    always_comb begin
        if (new_flags[FLAG_OVF])       new_code = CODE_OVF;
        else if (new_flags[FLAG_LOAD]) new_code = CODE_LOAD;
        else if (new_flags[FLAG_INC])  new_code = CODE_INC;
        else if (new_flags[FLAG_HOLD]) new_code = CODE_HOLD;
        else                           new_code = CODE_NONE;
    end

    assign any_err = |new_flags;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_UNSYNC;
            exp_q          <= '0;
            op_q           <= OP_HOLD;
            err_flags      <= '0;
            err_pulse      <= 1'b0;
            first_err_code <= CODE_NONE;
            first_err_data <= '0;
        end else begin
            exp_q     <= exp_nxt;
            op_q      <= op_nxt;
            err_pulse <= any_err;
            err_flags <= (err_clr ? 4'b0000 : err_flags) | new_flags;
            // A same-cycle error beats err_clr and becomes the new first error.
            if (any_err && (err_clr || (first_err_code == CODE_NONE))) begin
                first_err_code <= new_code;
                first_err_data <= data_out;
            end else if (err_clr) begin
                first_err_code <= CODE_NONE;
                first_err_data <= '0;
            end
            case (state)
                ST_UNSYNC: state <= ST_TRACK;
                ST_TRACK:  if ((STOP_ON_ERR != 0) && any_err) state <= ST_HALTED;
                default:   if (err_clr) state <= ST_UNSYNC;
            endcase
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (err_clr),
        .inc   (any_err),
        .count (err_count)
    );

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst && any_err)
            $display("counter_firewall: error cycle code=%0d data_out=%0d", new_code, data_out);
    end
`endif

endmodule

// File: tb/tb_counter_firewall.sv
// Directed bench for counter_firewall: default, wrap-allowed and stop-on-error builds.
module tb_counter_firewall;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ld = 1'b0;
    logic       inc = 1'b0;
    logic [2:0] data_in = '0;
    logic [2:0] data_out = '0;
    logic       err_clr = 1'b0;

    logic [3:0] d_flags, w_flags, s_flags;
    logic       d_pulse, w_pulse, s_pulse;
    logic [7:0] d_count, w_count, s_count;
    logic [2:0] d_code, w_code, s_code;
    logic [2:0] d_data, w_data, s_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    counter_firewall u_def (
        .clk(clk), .rst(rst), .ld(ld), .inc(inc), .data_in(data_in), .data_out(data_out),
        .err_clr(err_clr), .err_flags(d_flags), .err_pulse(d_pulse), .err_count(d_count),
        .first_err_code(d_code), .first_err_data(d_data)
    );

    counter_firewall #(.WRAP_OK(1)) u_wrap (
        .clk(clk), .rst(rst), .ld(ld), .inc(inc), .data_in(data_in), .data_out(data_out),
        .err_clr(err_clr), .err_flags(w_flags), .err_pulse(w_pulse), .err_count(w_count),
        .first_err_code(w_code), .first_err_data(w_data)
    );

    counter_firewall #(.STOP_ON_ERR(1)) u_stop (
        .clk(clk), .rst(rst), .ld(ld), .inc(inc), .data_in(data_in), .data_out(data_out),
        .err_clr(err_clr), .err_flags(s_flags), .err_pulse(s_pulse), .err_count(s_count),
        .first_err_code(s_code), .first_err_data(s_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic drive(input logic l, input logic i, input logic [2:0] din, input logic [2:0] dout);
        ld = l; inc = i; data_in = din; data_out = dout;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 3'd0, 3'd0);
        err_clr = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        // Reset values while rst is held low
        #3;
        check("rst_flags", d_flags, 0);
        check("rst_pulse", d_pulse, 0);
        check("rst_count", d_count, 0);
        check("rst_code", d_code, 0);
        check("rst_data", d_data, 0);
        tick();
        rst = 1'b1;

        // Load 5 then increment to 6, 7 and hold: clean
        drive(1, 0, 3'd5, 3'd0); tick();
        drive(0, 1, 3'd0, 3'd5); tick();
        drive(0, 1, 3'd0, 3'd6); tick();
        drive(0, 0, 3'd0, 3'd7); tick();
        check("clean_flags", d_flags, 0);
        check("clean_count", d_count, 0);
        check("clean_pulse", d_pulse, 0);

        // Increment from all-ones
        drive(0, 1, 3'd0, 3'd7); tick();
        check("ovf_flags", d_flags, 4'b0001);
        check("ovf_code", d_code, 1);
        check("ovf_data", d_data, 7);
        check("ovf_pulse", d_pulse, 1);
        check("ovf_count", d_count, 1);
        check("wrap_flags", w_flags, 0);
        check("wrap_count", w_count, 0);
        drive(0, 0, 3'd0, 3'd0); tick();
        check("ovf_pulse_drop", d_pulse, 0);
        check("ovf_count_hold", d_count, 1);
        check("ovf_flags_sticky", d_flags, 4'b0001);
        check("wrap_pulse", w_pulse, 0);
        check("wrap_flags2", w_flags, 0);

        // Load mismatch then resync
        do_reset();
        drive(0, 0, 3'd0, 3'd0); tick();
        drive(1, 0, 3'd3, 3'd0); tick();
        drive(0, 1, 3'd0, 3'd2); tick();
        check("ld_flags", d_flags, 4'b0010);
        check("ld_code", d_code, 2);
        check("ld_data", d_data, 2);
        check("ld_pulse", d_pulse, 1);
        drive(0, 0, 3'd0, 3'd3); tick();
        check("resync_count", d_count, 1);
        check("resync_pulse", d_pulse, 0);
        // err_clr in the same cycle as a hold mismatch: the error wins
        err_clr = 1'b1;
        drive(0, 0, 3'd0, 3'd5); tick();
        err_clr = 1'b0;
        check("clr_err_flags", d_flags, 4'b1000);
        check("clr_err_count", d_count, 1);
        check("clr_err_code", d_code, 4);
        check("clr_err_data", d_data, 5);

        // Hold with a toggling counter saturates the error count
        do_reset();
        drive(0, 0, 3'd0, 3'd4); tick();
        for (int i = 0; i < 255; i++) begin
            drive(0, 0, 3'd0, (i % 2 == 0) ? 3'd5 : 3'd4); tick();
        end
        check("sat_255", d_count, 255);
        for (int i = 255; i < 300; i++) begin
            drive(0, 0, 3'd0, (i % 2 == 0) ? 3'd5 : 3'd4); tick();
        end
        check("sat_hold", d_count, 255);
        check("sat_code", d_code, 4);
        check("sat_data", d_data, 5);
        check("sat_flags", d_flags, 4'b1000);

        // Stop-on-error build halts after one inc mismatch
        do_reset();
        drive(0, 0, 3'd0, 3'd0); tick();
        drive(0, 1, 3'd0, 3'd0); tick();
        drive(0, 1, 3'd0, 3'd3); tick();
        check("stop_count", s_count, 1);
        check("stop_code", s_code, 3);
        check("stop_flags", s_flags, 4'b0100);
        check("stop_pulse", s_pulse, 1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 3'd0, 3'(6 - i)); tick();
        end
        check("halt_count", s_count, 1);
        check("halt_pulse", s_pulse, 0);
        check("halt_flags", s_flags, 4'b0100);
        err_clr = 1'b1;
        drive(0, 0, 3'd0, 3'd6); tick();
        err_clr = 1'b0;
        check("sclr_flags", s_flags, 0);
        check("sclr_count", s_count, 0);
        check("sclr_code", s_code, 0);
        check("sclr_data", s_data, 0);
        drive(0, 0, 3'd0, 3'd6); tick();
        check("reseed_count", s_count, 0);
        drive(0, 0, 3'd0, 3'd2); tick();
        check("recheck_code", s_code, 4);
        check("recheck_count", s_count, 1);

        // Asynchronous reset with an error registered and another pending
        do_reset();
        drive(0, 0, 3'd0, 3'd0); tick();
        drive(0, 0, 3'd0, 3'd1); tick();
        check("pre_rst_pulse", d_pulse, 1);
        drive(0, 0, 3'd0, 3'd2);
        #2 rst = 1'b0;
        #1;
        check("arst_flags", d_flags, 0);
        check("arst_count", d_count, 0);
        check("arst_pulse", d_pulse, 0);
        check("arst_code", d_code, 0);
        check("arst_data", d_data, 0);
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_pulse", d_pulse, 0);
        check("post_rst_count", d_count, 0);
        tick();
        check("post_rst_pulse2", d_pulse, 0);
        check("post_rst_flags", d_flags, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_firewall.md
COUNTER_FIREWALL -- requirements
Module: counter_firewall

Interface
REQ-001 SHALL provide parameter WIDTH, default 3, monitored counter width.
REQ-002 SHALL provide parameter CNT_W, default 8, error-counter width.
REQ-003 SHALL provide parameter WRAP_OK, default 0; 1 makes increment-from-all-ones legal (wraps to 0).
REQ-004 SHALL provide parameter STOP_ON_ERR, default 0; 1 halts checking after first error.
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 ld  input  1  counter load command, priority over inc.
REQ-008 inc  input  1  counter increment command.
REQ-009 data_in  input  WIDTH  counter load value.
REQ-010 data_out  input  WIDTH  observed counter output.
REQ-011 err_clr  input  1  synchronous clear of flags, count and capture.
REQ-012 err_flags  output  4  sticky flags: [0] overflow, [1] load mismatch, [2] inc mismatch, [3] hold mismatch.
REQ-013 err_pulse  output  1  registered one-cycle strobe per cycle with any new error.
REQ-014 err_count  output  CNT_W  saturating count of error cycles.
REQ-015 first_err_code  output  3  code of first error: 0 none, 1 overflow, 2 load, 3 inc, 4 hold.
REQ-016 first_err_data  output  WIDTH  data_out sampled at first error.

Function
REQ-017 SHALL hold states UNSYNC, TRACK, HALTED in a registered FSM.
REQ-018 UNSYNC: on the first edge, seed expected value exp from data_out, record op, go TRACK; no checks.
REQ-019 Each edge SHALL compute next exp = data_in if ld, else exp+1 mod 2^WIDTH if inc, else exp, and record op (LOAD/INC/HOLD).
REQ-020 TRACK: data_out != exp SHALL raise the mismatch flag selected by the previous cycle's op (load/inc/hold).
REQ-021 After a mismatch, next exp SHALL be derived from observed data_out, not stale exp, so that one fault gives one error.
REQ-022 Overflow SHALL be raised when WRAP_OK=0, inc=1, ld=0 and data_out is all-ones in TRACK; same-cycle ld suppresses it.
REQ-023 Overflow and mismatch in the same cycle SHALL both set flags, count once, and first_err_code priority is overflow>load>inc>hold.
REQ-024 err_count SHALL increment by one per error cycle and hold at 2^CNT_W-1.
REQ-025 first_err_code/first_err_data SHALL capture only when first_err_code==0.
REQ-026 err_clr SHALL zero flags, count and capture, and HALTED SHALL go to UNSYNC; a same-cycle error wins (flag set, count=1, captured).
REQ-027 STOP_ON_ERR=1: TRACK SHALL go to HALTED on any error; HALTED performs no checks and holds outputs.
REQ-028 Simulation builds SHALL $display one message per error cycle with code and data_out; synthesis builds SHALL omit it.

Reset
REQ-029 rst low SHALL asynchronously force state UNSYNC, err_flags 0, err_pulse 0, err_count 0, first_err_code 0, first_err_data 0, exp 0.
REQ-030 Reset assertion mid-check SHALL discard any pending error with no pulse or count.

Structure
REQ-031 Shared package counter_fw_pkg SHALL hold error-code constants, flag bit indices, and state and op enumerations.
REQ-032 Saturating error counter SHALL be sub-module sat_counter (parameter width; inputs clear, inc).

Verification (WIDTH=3, CNT_W=8)
REQ-033 ld=1, data_in=5, then data_out=5, inc for 2 cycles with data_out 6,7 -> no flags, err_count 0.
REQ-034 data_out=7, inc=1, ld=0, WRAP_OK=0 -> err_flags=0001, first_err_code=1, first_err_data=7, err_pulse one cycle; WRAP_OK=1 -> no error.
REQ-035 ld=1, data_in=3, next data_out=2 -> err_flags[1]=1, code 2; then inc and data_out=3 -> no further error (resync).
REQ-036 Hold with data_out stuck-changing 4->5 for 300 cycles -> err_count saturates at 255, first_err_code stays 4.
REQ-037 STOP_ON_ERR=1, inc mismatch then further mismatches -> count 1, HALTED; err_clr -> all outputs 0, UNSYNC, rechecking resumes.
REQ-038 rst low mid-stream with error in flight -> all outputs 0 immediately, no pulse after release.
